hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the five-stage RV32 core. It is the control-side counterpart of the decode→execute pipeline register: it produces the stall, flush and forwarding selects that the pipe registers and the execute operand muxes consume. It detects load-use and branch/jump hazards and sequences a multi-cycle MUL/DIV occupancy of the E stage. Optional performance counters record stall and flush cycles.

## Interface
- MULDIV_CYCLES, default 4: total E-stage cycles for a MUL/DIV op; legal values 2..16.
- CNT_WIDTH, default 32: performance-counter width.

- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- Rs1D, Rs2D  in  5 each  source registers of the instruction in D.
- Rs1E, Rs2E, RdE  in  5 each  source and destination registers of the instruction in E.
- ResultSrcE  in  2  result select in E; 2'b01 = load.
- PCTakenE  in  1  a branch or jump in E redirects the PC.
- MulDivE  in  1  the instruction in E is a MUL/DIV op.
- RdM, RdW  in  5 each  destination registers in M and W.
- RegWriteM, RegWriteW  in  1 each  register-write enables in M and W.
- StallF, StallD, StallE  out  1 each  hold the PC, F/D and D/E registers.
- FlushD, FlushE, FlushM  out  1 each  bubble the F/D, D/E and E/M registers.
- ForwardAE, ForwardBE  out  2 each  operand select: 00 register file, 10 ALUResultM, 01 ResultW.
- MulDivBusy  out  1  MUL/DIV sequencer is in BUSY.
- StallCount, FlushCount  out  CNT_WIDTH each  performance counters.

## Operation
- Forwarding is combinational. ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E. Otherwise it is 01 if RegWriteW && RdW!=0 && RdW==Rs1E. Otherwise it is 00. M takes priority over W. ForwardBE uses the same rules on Rs2E. x0 is never forwarded.
- lwStall = (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- mdStall: MUL/DIV sequencer stall, defined below.
- StallF = StallD = lwStall | mdStall. StallE = mdStall. FlushM = mdStall.
- FlushD = PCTakenE & ~mdStall.
- FlushE = (lwStall | PCTakenE) & ~mdStall. A stall of E overrides any flush of E.
- MUL/DIV sequencer FSM, with state IDLE/BUSY and counter cnt (4 bits):
  - IDLE with MulDivE=1: mdStall=1, cnt ← MULDIV_CYCLES-2, next state BUSY.
  - IDLE with MulDivE=0: mdStall=0.
  - BUSY with cnt!=0: mdStall=1, cnt ← cnt-1.
  - BUSY with cnt==0: mdStall=0, next state IDLE. This is the completion cycle; the op leaves E at the next edge.
- One op therefore occupies E for exactly MULDIV_CYCLES cycles, with mdStall asserted for MULDIV_CYCLES-1 of them. Back-to-back ops re-enter BUSY from IDLE with no idle gap.
- MulDivBusy = (state==BUSY).

## Timing
- All outputs except the counters and MulDivBusy are combinational from inputs and state, with zero latency.
- Reset values: state=IDLE, cnt=0, StallCount=0, FlushCount=0, MulDivBusy=0.
- While rst=1, stall and flush outputs follow the combinational equations with state=IDLE.
- If rst is asserted mid-op, the sequencer returns to IDLE at the next edge. The E-stage op is not resumed.
- If lwStall and PCTakenE are both set, StallF/StallD/FlushE are set and FlushD is set. The branch wins; the stalled D instruction is squashed.
- If MulDivE and lwStall are both set, mdStall holds E, so lwStall cannot be resolved yet. StallF/StallD=1, FlushE=0, FlushM=1.

## Configuration
- HAZARD_PERF_CNT_EN defined: both counters increment by 1 on each clock where the condition holds, and are cleared by rst.
  - StallCount counts cycles with StallD=1.
  - FlushCount counts cycles with FlushE=1 or FlushD=1.
  - Both wrap modulo 2^CNT_WIDTH.
- HAZARD_PERF_CNT_EN undefined: no counter registers are built; StallCount and FlushCount are constant 0.

## Test plan
- RegWriteM=1, RdM=5, Rs1E=5, plus RegWriteW=1, RdW=5 → ForwardAE=10. With RdM=0 instead → ForwardAE=01. With Rs2E=0 → ForwardBE=00.
- ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1, FlushD=0 for one cycle. With RdE=0 → all 0.
- PCTakenE=1 → FlushD=FlushE=1, StallF=0. Combined with the load-use case above → FlushD=1, StallD=1.
- MULDIV_CYCLES=4, MulDivE held 1 → StallE=FlushM=1 for 3 cycles, 0 on the 4th. MulDivBusy=1 on cycles 2–4.
- rst pulsed on the 2nd cycle of a MUL/DIV op → state IDLE next cycle, MulDivBusy=0. With HAZARD_PERF_CNT_EN, counters read 0.
- HAZARD_PERF_CNT_EN with CNT_WIDTH=4: 17 load-use stall cycles → StallCount=1 (wrapped).

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the five-stage RV32
// pipeline, plus the sequencer that holds a MUL/DIV op in E for
// MULDIV_CYCLES cycles.
// Optional feature macro: HAZARD_PERF_CNT_EN builds the stall/flush cycle
// counters; without it StallCount and FlushCount are tied to zero.
module hazard_unit #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic [1:0]           ResultSrcE,
    input  logic                 PCTakenE,
    input  logic                 MulDivE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushM,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 MulDivBusy,
    output logic [CNT_WIDTH-1:0] StallCount,
    output logic [CNT_WIDTH-1:0] FlushCount
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Counter preload: the IDLE->BUSY cycle plus the cnt==0 completion cycle
    // account for two of the MULDIV_CYCLES occupancy cycles.
    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 2);

    md_state_e  state;
    md_state_e  state_next;
    md_state_e  state_eff;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       md_stall;
    logic       lw_stall;

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Sequencer next-state and occupancy counter
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (MulDivE) begin
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Sequencer outputs; while rst is high the stall logic sees IDLE so a
    // half-finished op cannot keep E held during reset
    always_comb begin
        state_eff = rst ? IDLE : state;
        md_stall  = 1'b0;
        unique case (state_eff)
            IDLE:    md_stall = MulDivE;
            BUSY:    md_stall = (cnt != 4'd0);
            default: md_stall = 1'b0;
        endcase
        MulDivBusy = (state == BUSY);
    end

    // Load-use detection and stall/flush combination; an E stall beats any E flush
    always_comb begin
        lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));
        StallF   = lw_stall | md_stall;
        StallD   = lw_stall | md_stall;
        StallE   = md_stall;
        FlushM   = md_stall;
        FlushD   = PCTakenE & ~md_stall;
        FlushE   = (lw_stall | PCTakenE) & ~md_stall;
    end

    // Operand forwarding, M stage has priority over W, x0 never forwarded
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Stall and flush cycle counters, wrapping at 2^CNT_WIDTH
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallD) begin
                StallCount <= StallCount + 1'b1;
            end
            if (FlushE | FlushD) begin
                FlushCount <= FlushCount + 1'b1;
            end
        end
    end
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
